// File: rtl/snn_class_if.sv
// Classification result handshake between the spike classifier and its consumer.
// The producer holds the result steady while class_valid is high.
interface snn_class_if #(
    parameter int NUM_NEURONS = 10,
    parameter int CNT_WIDTH   = 8
);
    localparam int IW = $clog2(NUM_NEURONS);

    logic                 class_valid;
    logic                 class_ready;
    logic [IW-1:0]        class_idx;
    logic [CNT_WIDTH-1:0] class_count;
    logic                 class_tie;

    modport master (
        output class_valid,
        output class_idx,
        output class_count,
        output class_tie,
        input  class_ready
    );

    modport slave (
        input  class_valid,
        input  class_idx,
        input  class_count,
        input  class_tie,
        output class_ready
    );
endinterface

// File: rtl/snn_spike_classifier.sv
// Spike-count classifier: accumulates per-neuron spikes over a window of
// sample ticks, then scans the counts sequentially for the winning class.
module snn_spike_classifier #(
    parameter int NUM_NEURONS = 10,
    parameter int CNT_WIDTH   = 8,
    parameter int WINDOW_LEN  = 784
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] fired_flags_in,
    input  logic [NUM_NEURONS-1:0] valid_flags_in,
    output logic                   busy,
    snn_class_if.master            cls
);
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int SW = $clog2(WINDOW_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [SW-1:0]        LAST_TCK = SW'(WINDOW_LEN - 1);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
    logic [SW-1:0]        sample_cnt;
    logic [IW-1:0]        scan_idx;
    logic [IW-1:0]        best_idx, best_idx_d, out_idx;
    logic [CNT_WIDTH-1:0] best_cnt, best_cnt_d, out_cnt;
    logic [CNT_WIDTH-1:0] scan_val;
    logic                 tie, tie_d, out_tie;
    logic                 tick, final_tick, scan_last;

    assign tick       = |valid_flags_in;
    assign final_tick = tick && (sample_cnt == LAST_TCK);
    assign scan_last  = (scan_idx == LAST_IDX);
    assign scan_val   = cnt_q[scan_idx];

    assign busy            = (state_q == ACCUM) || (state_q == SCAN);
    assign cls.class_valid = (state_q == DONE);
    assign cls.class_idx   = out_idx;
    assign cls.class_count = out_cnt;
    assign cls.class_tie   = out_tie;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (final_tick) state_d = SCAN;
            SCAN:    if (scan_last) state_d = DONE;
            DONE:    if (cls.class_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        best_cnt_d = best_cnt;
        best_idx_d = best_idx;
        tie_d      = tie;
        if (scan_idx == '0) begin
            best_cnt_d = scan_val;
            best_idx_d = '0;
            tie_d      = 1'b0;
        end else if (scan_val > best_cnt) begin
            best_cnt_d = scan_val;
            best_idx_d = scan_idx;
            tie_d      = 1'b0;
        end else if (scan_val == best_cnt) begin
            tie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_NEURONS; g++) cnt_q[g] <= '0;
            sample_cnt <= '0;
            scan_idx   <= '0;
            best_cnt   <= '0;
            best_idx   <= '0;
            tie        <= 1'b0;
            out_idx    <= '0;
            out_cnt    <= '0;
            out_tie    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int g = 0; g < NUM_NEURONS; g++) cnt_q[g] <= '0;
                        sample_cnt <= '0;
                    end
                end
                ACCUM: begin
                    for (int g = 0; g < NUM_NEURONS; g++) begin
                        if (valid_flags_in[g] && fired_flags_in[g] &&
                            cnt_q[g] != CNT_MAX)
                            cnt_q[g] <= cnt_q[g] + 1'b1;
                    end
                    if (tick) sample_cnt <= sample_cnt + 1'b1;
                    if (final_tick) begin
                        scan_idx <= '0;
                        best_cnt <= '0;
                        best_idx <= '0;
                        tie      <= 1'b0;
                    end
                end
                SCAN: begin
                    best_cnt <= best_cnt_d;
                    best_idx <= best_idx_d;
                    tie      <= tie_d;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        out_idx <= best_idx_d;
                        out_cnt <= best_cnt_d;
                        out_tie <= tie_d;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
